// File: rtl/dlatch_latch_if.sv
// Bundle for the latch data path: enable/data in, latch output, complement,
// close pulse and open-cycle counter out.
interface dlatch_latch_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) ();
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             close_pulse;
  logic [CNT_W-1:0] open_cnt;

  modport master (
    output en, d,
    input  q, q_n, close_pulse, open_cnt
  );

  modport slave (
    input  en, d,
    output q, q_n, close_pulse, open_cnt
  );
endinterface

// File: rtl/dlatch_latch.sv
// Clock-safe D-latch model: transparent combinational path plus an edge-sampled
// hold register, with a close-edge pulse and a saturating open-cycle counter.
module dlatch_latch #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dlatch_latch_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] hold;
  logic             en_q;
  logic             close_pulse;
  logic [CNT_W-1:0] open_cnt;

  // NOTE: all state lives in flops updated with non-blocking assignments; the
  // "latch" behaviour is a mux in front of a flop, so no real latch is inferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold        <= '0;
      en_q        <= 1'b0;
      close_pulse <= 1'b0;
      open_cnt    <= '0;
    end else begin
      if (bus.en) hold <= bus.d;
      en_q        <= bus.en;
      close_pulse <= en_q & ~bus.en;
      if (bus.en && open_cnt != CNT_MAX) open_cnt <= open_cnt + 1'b1;
    end
  end

  // Transparent path bypasses the register so a rising en shows d with no latency.
  assign bus.q           = bus.en ? bus.d : hold;
  assign bus.q_n         = ~bus.q;
  assign bus.close_pulse = close_pulse;
  assign bus.open_cnt    = open_cnt;

endmodule

// File: tb/tb_dlatch_latch.sv
// Directed bench for dlatch_latch: one default instance (WIDTH=1, CNT_W=8) and
// one wide instance (WIDTH=8, CNT_W=4) sharing clock, reset and enable.
module tb_dlatch_latch;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d_a;
  logic [7:0] d_b;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  dlatch_latch_if #(.WIDTH(1), .CNT_W(8)) if_a ();
  dlatch_latch_if #(.WIDTH(8), .CNT_W(4)) if_b ();

  assign if_a.en = en;
  assign if_a.d  = d_a;
  assign if_b.en = en;
  assign if_b.d  = d_b;

  dlatch_latch #(.WIDTH(1), .CNT_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  dlatch_latch #(.WIDTH(8), .CNT_W(4)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are changed only after this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] st;
    logic       last_d;
    int         pulses;

    // Reset sequence
    rst_n = 1'b0; en = 1'b0; d_a = 1'b1; d_b = 8'hFF;
    tick(); tick();
    check("rst_q",      if_a.q,           0);
    check("rst_q_n",    if_a.q_n,         1);
    check("rst_cnt",    if_a.open_cnt,    0);
    check("rst_pulse",  if_a.close_pulse, 0);
    check("rst_q_b",    if_b.q,           32'h00);
    check("rst_q_n_b",  if_b.q_n,         32'hFF);

    // Counter-driven sweep: en = st[2]^st[0], d = st[1]
    rst_n = 1'b1;
    st = 3'd0; last_d = 1'b0; pulses = 0;
    for (int i = 0; i < 16; i++) begin
      en = st[2] ^ st[0]; d_a = st[1]; d_b = {7'b0, st[1]};
      #1;
      check("sweep_q", if_a.q, en ? d_a : last_d);
      tick();
      if (en) last_d = d_a;
      if (if_a.close_pulse) pulses++;
      st = st + 3'd1;
    end
    check("sweep_cnt",    if_a.open_cnt, 8);
    check("sweep_pulses", pulses,        6);

    // Hold check
    en = 1'b1; d_a = 1'b1; tick();
    en = 1'b0; pulses = 0;
    tick();
    check("hold_q0", if_a.q, 1);
    if (if_a.close_pulse) pulses++;
    for (int i = 0; i < 5; i++) begin
      d_a = ~d_a;
      tick();
      check("hold_q", if_a.q, 1);
      if (if_a.close_pulse) pulses++;
    end
    check("hold_pulses", pulses, 1);

    // Saturation: wide instance has CNT_W=4 and is at 9 here
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 5) check("sat_reach", if_b.open_cnt, 15);
    end
    check("sat_stay", if_b.open_cnt, 15);
    check("cnt_a_29", if_a.open_cnt, 29);

    // Reset mid-hold
    en = 1'b1; d_a = 1'b1; tick();
    en = 1'b0; rst_n = 1'b0; tick();
    check("rmid_q",     if_a.q,           0);
    check("rmid_q_n",   if_a.q_n,         1);
    check("rmid_cnt",   if_a.open_cnt,    0);
    check("rmid_cnt_b", if_b.open_cnt,    0);
    check("rmid_pulse", if_a.close_pulse, 0);
    en = 1'b1; d_a = 1'b1;
    #1;
    check("rst_transp", if_a.q, 1);
    tick();
    en = 1'b0;
    #1;
    check("rst_hold0", if_a.q,        0);
    check("rst_cnt0",  if_a.open_cnt, 0);

    // First enabled edge out of reset
    rst_n = 1'b1; tick();
    en = 1'b1; d_a = 1'b1; tick();
    check("first_cnt", if_a.open_cnt, 1);
    en = 1'b0; d_a = 1'b0;
    #1;
    check("first_q", if_a.q, 1);

    // Width check, then an enable glitch between edges
    en = 1'b1; d_b = 8'hA5; tick();
    en = 1'b0; d_b = 8'h3C;
    #1;
    check("w_q",   if_b.q,   32'hA5);
    check("w_q_n", if_b.q_n, 32'h5A);
    tick();
    check("w_q_edge", if_b.q, 32'hA5);
    en = 1'b1;
    #1;
    check("async_open", if_b.q, 32'h3C);
    en = 1'b0;
    #1;
    check("async_close", if_b.q, 32'hA5);
    tick();
    check("async_hold", if_b.q, 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dlatch_latch.md
DLATCH_LATCH -- requirements
Module: Dlatch

Interface
REQ-001 Parameter WIDTH, default 1: data width of d, q and q_n.
REQ-002 Parameter CNT_W, default 8: width of the open-cycle counter.
REQ-003 Clocking: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  single clock; every register updates on its rising edge only.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled at the rising edge of clk.
REQ-006 en  input  1  latch enable; 1 = transparent, 0 = hold.
REQ-007 d  input  WIDTH  data input.
REQ-008 q  output  WIDTH  latch output.
REQ-009 q_n  output  WIDTH  bitwise complement of q.
REQ-010 close_pulse  output  1  one-cycle pulse marking an en 1->0 transition.
REQ-011 open_cnt  output  CNT_W  saturating count of clock edges sampled with en=1.

Function
REQ-012 Internal hold register hold[WIDTH-1:0] stores the last transparent value.
REQ-013 q is combinational: q = d when en=1, q = hold when en=0; no clock latency on the transparent path.
REQ-014 q_n = ~q at all times, including during reset.
REQ-015 At each rising clk edge with rst_n=1 and en=1: hold <= d.
REQ-016 At each rising clk edge with rst_n=1 and en=0: hold keeps its value.
REQ-017 d changes while en=0 never affect q or hold.
REQ-018 en_q register stores en each edge; close_pulse = en_q & ~en, registered, so it is high for exactly one cycle after the edge where en_q=1 and en=0.
REQ-019 open_cnt increments by 1 at each edge with rst_n=1 and en=1, saturates at 2^CNT_W-1, and never wraps.
REQ-020 Simultaneous en fall and d change in the same cycle: q shows hold, which holds the d value sampled at the last edge with en=1.
REQ-021 An asynchronous en change between edges shows on q immediately; hold reflects only values sampled at edges.
REQ-022 All outputs are free of X once reset has been applied, for any known d and en.

Reset
REQ-023 At a rising edge with rst_n=0: hold <= 0, en_q <= 0, close_pulse <= 0, open_cnt <= 0.
REQ-024 Reset takes priority over the en/d update at the same edge.
REQ-025 While rst_n=0 and en=1, q still follows d combinationally; after reset, a closed latch shows q=0.
REQ-026 Reset applied mid-hold clears the held value: q=0, q_n=all ones after the reset edge with en=0.
REQ-027 Out of reset, the first edge with en=1 loads d and counts 1.

Verification
REQ-028 Reset sequence: rst_n=0 for 2 edges with en=0 and d=1 -> q=0, q_n=1, open_cnt=0, close_pulse=0.
REQ-029 Counter-driven sweep: a 3-bit state increments each edge, en=state[2]^state[0] and d=state[1] -> q equals d in every cycle with en=1, and equals the last d sampled with en=1 in every cycle with en=0.
REQ-030 Hold check: with en=1 and d=1, drop en to 0, then toggle d 0/1 for 5 cycles -> q stays 1 and close_pulse is high for exactly one cycle.
REQ-031 Saturation check: with CNT_W=4, hold en=1 for 20 edges -> open_cnt reaches 15 and stays at 15.
REQ-032 Reset mid-hold: after en=1 and d=1, set en=0 and apply rst_n=0 for 1 edge -> q=0 and open_cnt=0; with en=1 and d=1 during reset, q=1 combinationally and hold=0 after the edge.
REQ-033 Width check: with WIDTH=8, d=8'hA5 and en=1, then en=0 and d=8'h3C -> q=8'hA5 and q_n=8'h5A.
